// File: rtl/cdec_dpw.sv
// CDEC datapath: W-bit XBUS datapath with ALU, PC auto-increment,
// ready/ack memory FSM with timeout and registered debug readback.
module cdec_dpw #(
   parameter int W   = 8,
   parameter int NGR = 3,
   parameter int TMO = 15
) (
   input  logic         clock,
   input  logic         reset_N,
   input  logic [3:0]   xsrc,
   input  logic [3:0]   xdst,
   input  logic         xwr,
   input  logic [2:0]   aluop,
   input  logic         rwr,
   input  logic         fwr,
   input  logic         pc_inc,
   input  logic         mem_rd,
   input  logic         mem_wr,
   output logic         mem_req,
   output logic         mem_we,
   input  logic         mem_ack,
   output logic [W-1:0] adrs,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out,
   output logic         busy,
   output logic         bus_err,
   output logic [W-1:0] I,
   output logic [3:0]   SZCyV,
   input  logic [4:0]   resad,
   output logic [W-1:0] resdt
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   logic [W-1:0] pc_r, i_r, t_r, r_r, mar_r, wdr_r, rdr_r, resdt_r;
   logic [3:0]   flg_r;
   logic [W-1:0] gr_r [NGR];
   logic [1:0]   state_r;
   logic [7:0]   timer_r;
   logic         bus_err_r;
   logic [W-1:0] xbus_s, alu_res_s, res_sel_s;
   logic [W:0]   wide_s;
   logic         cy_s, v_s;

   // XBUS source multiplexer; unmapped codes read as all-ones
   always_comb begin
      xbus_s = {W{1'b1}};
      case (xsrc)
         4'd0: xbus_s = pc_r;
         4'd1: xbus_s = r_r;
         4'd2: xbus_s = rdr_r;
         4'd3: xbus_s = W'(flg_r);
         default: begin
            for (int k = 0; k < NGR; k++) begin
               xbus_s = (xsrc == 4'(k + 4)) ? gr_r[k] : xbus_s;
            end
         end
      endcase
   end

   // ALU: W+1 bit result carries the carry/borrow out of the add ops
   always_comb begin
      wide_s = {(W+1){1'b0}};
      cy_s   = 1'b0;
      v_s    = 1'b0;
      case (aluop)
         3'd0: begin
            wide_s = {1'b0, xbus_s} + {1'b0, t_r};
            cy_s   = wide_s[W];
            v_s    = (xbus_s[W-1] == t_r[W-1]) && (wide_s[W-1] != xbus_s[W-1]);
         end
         3'd1: begin
            wide_s = {1'b0, xbus_s} + {1'b0, t_r} + {{W{1'b0}}, flg_r[1]};
            cy_s   = wide_s[W];
            v_s    = (xbus_s[W-1] == t_r[W-1]) && (wide_s[W-1] != xbus_s[W-1]);
         end
         3'd2: begin
            wide_s = {1'b0, xbus_s} - {1'b0, t_r};
            cy_s   = wide_s[W];
            v_s    = (xbus_s[W-1] != t_r[W-1]) && (wide_s[W-1] != xbus_s[W-1]);
         end
         3'd3: wide_s = {1'b0, xbus_s & t_r};
         3'd4: wide_s = {1'b0, xbus_s | t_r};
         3'd5: wide_s = {1'b0, xbus_s ^ t_r};
         3'd6: begin
            wide_s = {1'b0, xbus_s[W-2:0], 1'b0};
            cy_s   = xbus_s[W-1];
         end
         3'd7: begin
            wide_s = {2'b00, xbus_s[W-1:1]};
            cy_s   = xbus_s[0];
         end
         default: wide_s = {(W+1){1'b0}};
      endcase
      alu_res_s = wide_s[W-1:0];
   end

   // Datapath registers; an XBUS write to PC overrides the increment
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         pc_r  <= '0;
         i_r   <= '0;
         t_r   <= '0;
         r_r   <= '0;
         mar_r <= '0;
         wdr_r <= '0;
         flg_r <= 4'd0;
         for (int k = 0; k < NGR; k++) gr_r[k] <= '0;
      end else begin
         if (xwr && xdst == 4'd0) pc_r <= xbus_s;
         else if (pc_inc)         pc_r <= pc_r + {{(W-1){1'b0}}, 1'b1};
         if (xwr && xdst == 4'd1) i_r   <= xbus_s;
         if (xwr && xdst == 4'd2) t_r   <= xbus_s;
         if (xwr && xdst == 4'd3) mar_r <= xbus_s;
         if (xwr && xdst == 4'd4) wdr_r <= xbus_s;
         for (int k = 0; k < NGR; k++) begin
            if (xwr && xdst == 4'(k + 5)) gr_r[k] <= xbus_s;
         end
         if (rwr) r_r   <= alu_res_s;
         if (fwr) flg_r <= {alu_res_s[W-1], ~|alu_res_s, cy_s, v_s};
      end
   end

   // Memory FSM; ack takes priority over a timeout in the same cycle
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_r   <= ST_IDLE;
         timer_r   <= 8'd0;
         bus_err_r <= 1'b0;
         rdr_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               timer_r <= 8'd0;
               if (mem_rd)      state_r <= ST_RD;
               else if (mem_wr) state_r <= ST_WR;
            end
            ST_RD, ST_WR: begin
               if (mem_ack) begin
                  state_r <= ST_IDLE;
                  if (state_r == ST_RD) rdr_r <= data_in;
               end else if (timer_r == 8'(TMO - 1)) begin
                  state_r   <= ST_IDLE;
                  bus_err_r <= 1'b1;
               end else begin
                  timer_r <= timer_r + 8'd1;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Debug resource selector
   always_comb begin
      res_sel_s = '0;
      case (resad)
         5'd0: res_sel_s = pc_r;
         5'd1: res_sel_s = i_r;
         5'd2: res_sel_s = t_r;
         5'd3: res_sel_s = r_r;
         5'd4: res_sel_s = mar_r;
         5'd5: res_sel_s = data_in;
         5'd6: res_sel_s = rdr_r;
         5'd7: res_sel_s = wdr_r;
         5'd8: res_sel_s = W'(flg_r);
         5'd9: res_sel_s = W'({state_r, bus_err_r});
         default: begin
            for (int k = 0; k < NGR; k++) begin
               res_sel_s = (resad == 5'(k + 16)) ? gr_r[k] : res_sel_s;
            end
         end
      endcase
   end

   // Debug readback register
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) resdt_r <= '0;
      else          resdt_r <= res_sel_s;
   end

   assign mem_req  = (state_r != ST_IDLE);
   assign busy     = (state_r != ST_IDLE);
   assign mem_we   = (state_r == ST_WR);
   assign bus_err  = bus_err_r;
   assign adrs     = mar_r;
   assign data_out = wdr_r;
   assign I        = i_r;
   assign SZCyV    = flg_r;
   assign resdt    = resdt_r;
endmodule

// File: tb/tb_cdec_dpw.sv
// Self-checking bench for cdec_dpw: randomized datapath/memory traffic
// against an arithmetic reference model, plus a W=16/NGR=5 instance.
module tb_cdec_dpw;
   localparam int W   = 8;
   localparam int NGR = 3;
   localparam int TMO = 15;
   localparam int M   = 1 << W;

   logic clock = 1'b0, reset_N = 1'b0;
   logic [3:0] xsrc = 4'd0, xdst = 4'd0;
   logic [2:0] aluop = 3'd0;
   logic xwr = 1'b0, rwr = 1'b0, fwr = 1'b0, pc_inc = 1'b0;
   logic mem_rd = 1'b0, mem_wr = 1'b0, mem_ack = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [4:0] resad = 5'd0;
   logic mem_req, mem_we, busy, bus_err;
   logic [W-1:0] adrs, data_out, I, resdt;
   logic [3:0] SZCyV;

   logic [3:0] b_xsrc = 4'd0, b_xdst = 4'd0;
   logic b_xwr = 1'b0, b_mem_rd = 1'b0, b_mem_ack = 1'b0;
   logic [15:0] b_data_in = 16'd0;
   logic [4:0] b_resad = 5'd0;
   logic b_mem_req, b_mem_we, b_busy, b_bus_err;
   logic [15:0] b_adrs, b_data_out, b_I, b_resdt;
   logic [3:0] b_SZCyV;

   int n_tests = 0, n_fail = 0;
   int m_pc, m_i, m_t, m_r, m_mar, m_wdr, m_rdr, m_flg, m_berr;
   int m_gr [NGR];

   cdec_dpw #(.W(W), .NGR(NGR), .TMO(TMO)) dut (
      .clock(clock), .reset_N(reset_N), .xsrc(xsrc), .xdst(xdst), .xwr(xwr),
      .aluop(aluop), .rwr(rwr), .fwr(fwr), .pc_inc(pc_inc), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
      .adrs(adrs), .data_in(data_in), .data_out(data_out), .busy(busy),
      .bus_err(bus_err), .I(I), .SZCyV(SZCyV), .resad(resad), .resdt(resdt));

   cdec_dpw #(.W(16), .NGR(5), .TMO(TMO)) dut_w16 (
      .clock(clock), .reset_N(reset_N), .xsrc(b_xsrc), .xdst(b_xdst), .xwr(b_xwr),
      .aluop(3'd0), .rwr(1'b0), .fwr(1'b0), .pc_inc(1'b0), .mem_rd(b_mem_rd),
      .mem_wr(1'b0), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_ack(b_mem_ack),
      .adrs(b_adrs), .data_in(b_data_in), .data_out(b_data_out), .busy(b_busy),
      .bus_err(b_bus_err), .I(b_I), .SZCyV(b_SZCyV), .resad(b_resad), .resdt(b_resdt));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_i = 0; m_t = 0; m_r = 0; m_mar = 0; m_wdr = 0; m_rdr = 0; m_flg = 0; m_berr = 0;
      for (int k = 0; k < NGR; k++) m_gr[k] = 0;
   endtask

   function automatic int src_val(input int s);
      if (s == 0) return m_pc;
      if (s == 1) return m_r;
      if (s == 2) return m_rdr;
      if (s == 3) return m_flg;
      if (s >= 4 && s < 4 + NGR) return m_gr[s-4];
      return M - 1;
   endfunction

   function automatic int res_val(input int a, input int din);
      case (a)
         0: return m_pc;
         1: return m_i;
         2: return m_t;
         3: return m_r;
         4: return m_mar;
         5: return din;
         6: return m_rdr;
         7: return m_wdr;
         8: return m_flg;
         default: begin
            if (a >= 16 && a < 16 + NGR) return m_gr[a-16];
            return 0;
         end
      endcase
   endfunction

   // Reference ALU on unsigned/signed integers; flags packed as S*8+Z*4+Cy*2+V
   function automatic void alu_ref(input int op, input int x, input int t, input int c,
                                   output int res, output int f);
      int sx, st, ss, full, cy, v;
      sx = (x >= M/2) ? x - M : x;
      st = (t >= M/2) ? t - M : t;
      ss = 0; cy = 0; v = 0;
      case (op)
         0: begin full = x + t;     ss = sx + st;     end
         1: begin full = x + t + c; ss = sx + st + c; end
         2: begin full = x - t;     ss = sx - st;     end
         3: full = x & t;
         4: full = x | t;
         5: full = x ^ t;
         6: full = x * 2;
         7: full = x / 2;
         default: full = 0;
      endcase
      if (op <= 1)      cy = (full >= M) ? 1 : 0;
      else if (op == 2) cy = (x < t) ? 1 : 0;
      else if (op == 6) cy = (x >= M/2) ? 1 : 0;
      else if (op == 7) cy = x % 2;
      if (op <= 2) v = (ss > M/2 - 1 || ss < -(M/2)) ? 1 : 0;
      res = ((full % M) + M) % M;
      f = ((res >= M/2) ? 8 : 0) + ((res == 0) ? 4 : 0) + cy * 2 + v;
   endfunction

   task automatic do_cycle(input int s, input int d, input bit w, input int op, input bit rw,
                           input bit fw, input bit pi, input int ra, input int din);
      int x, res, f, exp_res;
      xsrc = 4'(s); xdst = 4'(d); xwr = w; aluop = 3'(op); rwr = rw; fwr = fw;
      pc_inc = pi; resad = 5'(ra); data_in = W'(din);
      mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'($urandom_range(1));
      x = src_val(s);
      alu_ref(op, x, m_t, (m_flg >> 1) & 1, res, f);
      exp_res = res_val(ra, din);
      @(posedge clock); #1;
      if (w && d == 0) m_pc = x;
      else if (pi)     m_pc = (m_pc + 1) % M;
      if (w && d == 1) m_i = x;
      if (w && d == 2) m_t = x;
      if (w && d == 3) m_mar = x;
      if (w && d == 4) m_wdr = x;
      for (int k = 0; k < NGR; k++) if (w && d == 5 + k) m_gr[k] = x;
      if (rw) m_r = res;
      if (fw) m_flg = f;
      if (ra == 9) check("res_berr", 32'(resdt[0]), m_berr);
      else         check("resdt", resdt, exp_res);
      check("I", I, m_i);
      check("SZCyV", SZCyV, m_flg);
      check("adrs", adrs, m_mar);
      check("data_out", data_out, m_wdr);
      check("idle_req", mem_req, 0);
      check("idle_busy", busy, 0);
      check("bus_err", bus_err, m_berr);
      xwr = 1'b0; rwr = 1'b0; fwr = 1'b0; pc_inc = 1'b0; mem_ack = 1'b0;
   endtask

   // lat in 1..TMO acks on that cycle of mem_req; any other lat never acks
   task automatic mem_txn(input bit rd, input bit both, input int dv, input int lat, input bit stray);
      int n, exp_n;
      xwr = 1'b0; rwr = 1'b0; fwr = 1'b0; pc_inc = 1'b0; mem_ack = 1'b0; resad = 5'd6;
      mem_rd = rd | both; mem_wr = ~rd | both; data_in = W'(dv);
      @(posedge clock); #1;
      mem_rd = 1'b0; mem_wr = 1'b0;
      check("req_start", mem_req, 1);
      check("busy_start", busy, 1);
      check("mem_we", mem_we, (rd | both) ? 0 : 1);
      n = 0;
      while (mem_req === 1'b1 && n < 4 * TMO) begin
         n++;
         mem_ack = (n == lat);
         mem_wr = stray;
         @(posedge clock); #1;
         mem_ack = 1'b0; mem_wr = 1'b0;
      end
      exp_n = (lat >= 1 && lat <= TMO) ? lat : TMO;
      check("req_cycles", n, exp_n);
      check("busy_end", busy, 0);
      if (lat >= 1 && lat <= TMO) begin
         if (rd | both) m_rdr = dv;
      end else begin
         m_berr = 1;
      end
      check("bus_err_txn", bus_err, m_berr);
   endtask

   task automatic load_reg(input int d, input int v);
      mem_txn(1'b1, 1'b0, v, 1, 1'b0);
      do_cycle(2, d, 1'b1, 0, 1'b0, 1'b0, 1'b0, 6, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_req", mem_req, 0);
      check("rst_busy", busy, 0);
      check("rst_berr", bus_err, 0);
      check("rst_resdt", resdt, 0);
      check("rst_I", I, 0);
      check("rst_flg", SZCyV, 0);
      check("rst_adrs", adrs, 0);
      check("rst_dout", data_out, 0);
      reset_N = 1'b1;

      // ADD 0x7F + 0x01 -> 0x80, S=1 V=1
      load_reg(2, 8'h7F);
      load_reg(5, 8'h01);
      do_cycle(4, 15, 1'b0, 0, 1'b1, 1'b1, 1'b0, 3, 0);
      check("add_flg", SZCyV, 4'b1001);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3, 0);
      check("add_r", resdt, 8'h80);
      // SUB 0x00 - 0x01 -> 0xFF with borrow
      load_reg(2, 8'h01);
      load_reg(6, 8'h00);
      do_cycle(5, 15, 1'b0, 2, 1'b1, 1'b1, 1'b0, 3, 0);
      check("sub_flg", SZCyV, 4'b1010);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3, 0);
      check("sub_r", resdt, 8'hFF);
      // PC wrap and XBUS write beating increment
      load_reg(0, 8'hFF);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 0);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("pc_wrap", resdt, 8'h00);
      load_reg(7, 8'h42);
      do_cycle(6, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 0);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("pc_xwr_wins", resdt, 8'h42);
      // Read with 3-cycle ack and stray mem_wr, then write and dual request
      load_reg(3, 8'h10);
      check("mar_adrs", adrs, 8'h10);
      mem_txn(1'b1, 1'b0, 8'hA5, 3, 1'b1);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6, 0);
      check("rdr_a5", resdt, 8'hA5);
      load_reg(4, 8'h3C);
      mem_txn(1'b0, 1'b0, 0, 2, 1'b0);
      mem_txn(1'b1, 1'b1, 8'h5A, 1, 1'b0);
      // Timeout leaves RDR alone and bus_err sticks through good cycles
      mem_txn(1'b1, 1'b0, 8'h99, 0, 1'b0);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6, 0);
      mem_txn(1'b1, 1'b0, 8'h77, 2, 1'b0);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 9, 0);

      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(9) == 0)
            mem_txn(1'($urandom_range(1)), 1'($urandom_range(3) == 0), int'($urandom_range(M-1)),
                    int'($urandom_range(TMO)), 1'($urandom_range(1)));
         else
            do_cycle(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom_range(1)),
                     int'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(M-1)));
      end

      // Asynchronous reset in the middle of a read cycle
      mem_rd = 1'b1;
      @(posedge clock); #1;
      mem_rd = 1'b0;
      check("mid_req", mem_req, 1);
      @(posedge clock); #3;
      reset_N = 1'b0;
      #1;
      check("arst_req", mem_req, 0);
      check("arst_busy", busy, 0);
      check("arst_berr", bus_err, 0);
      check("arst_resdt", resdt, 0);
      check("arst_I", I, 0);
      check("arst_adrs", adrs, 0);
      model_reset();
      @(posedge clock); #1;
      reset_N = 1'b1;
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6, 0);
      do_cycle(15, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

      // W=16, NGR=5: GR[4] round trip and readback
      b_mem_rd = 1'b1; b_data_in = 16'hBEEF;
      @(posedge clock); #1;
      b_mem_rd = 1'b0; b_mem_ack = 1'b1;
      @(posedge clock); #1;
      b_mem_ack = 1'b0;
      check("w16_idle", b_busy, 0);
      b_xsrc = 4'd2; b_xdst = 4'd9; b_xwr = 1'b1;
      @(posedge clock); #1;
      b_xsrc = 4'd8; b_xdst = 4'd2;
      @(posedge clock); #1;
      b_xwr = 1'b0; b_resad = 5'd2;
      @(posedge clock); #1;
      check("w16_t", b_resdt, 16'hBEEF);
      b_resad = 5'd20;
      @(posedge clock); #1;
      check("w16_gr4", b_resdt, 16'hBEEF);
      b_resad = 5'd31;
      @(posedge clock); #1;
      check("w16_res31", b_resdt, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
